spike_rate_decoder: RTL and testbench
=====================================

Name: spike_rate_decoder

Overview:
- Reader side of the neuron spike interface: consumes the single-bit spike train produced by a LIF neuron (its registered spike output).
- Counts spikes over a fixed window of WINDOW enabled cycles and reports the count in the same saturating (V_SIZE+1)-bit current format the neuron input uses (MSB = overflow, all-ones = INF).
- Also reports the first-spike time within the window.
- Sits between a neuron layer output and readout / classification logic.

Parameters:
- V_SIZE, 4, valid count bits; count bus is V_SIZE+1 wide, all-ones = INF (saturated).
- WINDOW, 16, enabled cycles per window; must be >= 2.
- T_SIZE, 5, width of the window index and the first-spike time; 2^T_SIZE > WINDOW-1.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  window advances and samples spike_in only when high.
- clear  input  1  synchronous window restart; priority over en.
- spike_in  input  1  spike from neuron, sampled on the clock edge.
- count_out  output  V_SIZE+1  spike count of the last completed window (INF if saturated).
- first_out  output  T_SIZE  window index of the first spike in the last completed window.
- first_valid  output  1  last completed window contained at least one spike.
- out_valid  output  1  one-cycle pulse: outputs updated this cycle.

Behaviour:
- Reset (rstn low, asynchronous):
  - Window index t, count accumulator acc, first accumulator and seen flag cleared.
  - count_out=0, first_out=0, first_valid=0, out_valid=0.
  - Reset mid-window discards the partial window.
- Internal state:
  - t in 0..WINDOW-1.
  - acc, V_SIZE+1 bits.
  - facc, T_SIZE bits.
  - seen, 1 bit.
- Priority per clock edge: clear > en > hold.
- clear=1:
  - t, acc, facc and seen go to 0; out_valid=0.
  - count_out, first_out and first_valid hold their previous values.
- en=0 (and clear=0):
  - All state and outputs hold; spike_in ignored; out_valid=0.
- en=1, t<WINDOW-1:
  - t<=t+1.
  - If spike_in: acc<=sat(acc+1). If seen=0, facc<=t and seen<=1.
  - out_valid=0.
- en=1, t==WINDOW-1 (window close):
  - The final-cycle spike is included in the result.
  - count_out<=sat(acc+spike_in).
  - first_valid<=seen|spike_in.
  - first_out<=seen ? facc : (spike_in ? WINDOW-1 : 0).
  - out_valid<=1 for exactly this one cycle.
  - t, acc, facc and seen go to 0, so the next window starts with no gap cycle.
- Saturation rule sat(x):
  - Values 0..2^V_SIZE-1 pass unchanged.
  - Any result with bit V_SIZE set becomes INF (all ones).
  - INF is sticky until the window closes.
  - With V_SIZE=4: 15 spikes give 15; 16 or more give 31.
- Latency: outputs and out_valid appear in the cycle after the rising edge that sampled the last window cycle.
- Outputs remain stable between out_valid pulses.
- out_valid never asserts during reset, clear or en=0 cycles.
- No backpressure: a consumer must capture results on out_valid.

Test Plan:
- Reset: assert rstn=0 mid-window with 5 spikes accumulated, release, then run a full window with no spikes. Required: all outputs 0 during reset; the next window reports count_out=0, first_valid=0 (the 5 spikes are discarded).
- Sparse window: WINDOW=16, en=1, spikes at t=2,5,9. Required: out_valid pulses once after the 16th enabled cycle, count_out=3, first_out=2, first_valid=1.
- Saturation:
  - spike_in=1 for all 16 cycles gives count_out=31 (INF), first_out=0.
  - Spikes on 15 cycles, none at t=0, give count_out=15, first_out=1.
- Edge spike: only spike at t=15 gives count_out=1, first_out=15, first_valid=1. The following empty window gives count_out=0, first_valid=0, first_out=0.
- en gaps: toggle en low for 3 cycles at t=4 and 7 cycles at t=10 while spike_in=1 during the gaps, with spikes at t=4 and t=12 when enabled. Required: out_valid after 16 enabled cycles (26 total clocks), count_out=2, first_out=4.
- clear: assert clear at t=8 after 4 spikes, then run a full window with 1 spike at t=3. Required: no out_valid at the clear, previous outputs held; the next result is count_out=1, first_out=3.

Source files
------------

// File: rtl/spike_rate_decoder.sv
// Spike rate decoder: counts the spikes a neuron emits over a window of
// WINDOW enabled cycles and reports the saturating count plus the index of
// the first spike seen in that window.
//
// Output handshake: out_valid is a one-cycle pulse with no ready. count_out,
// first_out and first_valid change only in the cycle out_valid is high. They
// hold their values until the next pulse, so a consumer must capture them on
// out_valid.
module spike_rate_decoder #(
  parameter int V_SIZE = 4,   // valid count bits; count bus is V_SIZE+1 wide
  parameter int WINDOW = 16,  // enabled cycles per window, >= 2
  parameter int T_SIZE = 5    // window index width, 2**T_SIZE > WINDOW-1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              clear,
  input  logic              spike_in,
  output logic [V_SIZE:0]   count_out,
  output logic [T_SIZE-1:0] first_out,
  output logic              first_valid,
  output logic              out_valid
);

  localparam logic [T_SIZE-1:0] T_LAST = T_SIZE'(WINDOW - 1);
  localparam logic [V_SIZE:0]   INF    = '1;

  logic [T_SIZE-1:0] t;
  logic [T_SIZE-1:0] facc;
  logic [V_SIZE:0]   acc;
  logic              seen;
  logic [V_SIZE:0]   acc_inc;
  logic [V_SIZE:0]   acc_sat;

  // Saturating accumulate. INF is sticky because its MSB is already set, and
  // an increment from INF that wraps is still forced back to INF.
  always_comb begin
    acc_inc = acc + {{V_SIZE{1'b0}}, spike_in};
    acc_sat = acc_inc;
    if (acc[V_SIZE] || acc_inc[V_SIZE]) begin
      acc_sat = INF;
    end
  end

  // Window sequencing, accumulation and result publication. Priority is
  // clear > en > hold.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t           <= '0;
      acc         <= '0;
      facc        <= '0;
      seen        <= 1'b0;
      count_out   <= '0;
      first_out   <= '0;
      first_valid <= 1'b0;
      out_valid   <= 1'b0;
    end else if (clear) begin
      // Restart the window; published results stay visible.
      t         <= '0;
      acc       <= '0;
      facc      <= '0;
      seen      <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (t == T_LAST) begin
        // Window close: the spike sampled on this last cycle still counts.
        count_out   <= acc_sat;
        first_valid <= seen | spike_in;
        if (seen) begin
          first_out <= facc;
        end else if (spike_in) begin
          first_out <= T_LAST;
        end else begin
          first_out <= '0;
        end
        out_valid <= 1'b1;
        // Next window starts on the following enabled cycle, no gap.
        t         <= '0;
        acc       <= '0;
        facc      <= '0;
        seen      <= 1'b0;
      end else begin
        t         <= t + 1'b1;
        out_valid <= 1'b0;
        if (spike_in) begin
          acc <= acc_sat;
          if (!seen) begin
            facc <= t;
            seen <= 1'b1;
          end
        end
      end
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: table of full windows plus hand-built
// sequences for reset, enable gaps and clear. Expected window results are
// queued when a window is driven and checked when out_valid pulses.
module tb_spike_rate_decoder;

  localparam int V_SIZE = 4;
  localparam int WINDOW = 16;
  localparam int T_SIZE = 5;
  localparam int W      = V_SIZE + 1 + T_SIZE + 1;  // {count, first, first_valid}

  logic              clk;
  logic              rstn;
  logic              en;
  logic              clear;
  logic              spike_in;
  logic [V_SIZE:0]   count_out;
  logic [T_SIZE-1:0] first_out;
  logic              first_valid;
  logic              out_valid;

  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  spike_rate_decoder #(
    .V_SIZE(V_SIZE),
    .WINDOW(WINDOW),
    .T_SIZE(T_SIZE)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .clear      (clear),
    .spike_in   (spike_in),
    .count_out  (count_out),
    .first_out  (first_out),
    .first_valid(first_valid),
    .out_valid  (out_valid)
  );

  // Clock and initial reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [WINDOW-1:0] mask;  // bit i = spike at window index i
    logic [V_SIZE:0]   exp_count;
    logic [T_SIZE-1:0] exp_first;
    logic              exp_fv;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [W-1:0] pack(input logic [V_SIZE:0] c,
                                        input logic [T_SIZE-1:0] f,
                                        input logic v);
    return {c, f, v};
  endfunction

  // Reference model: population count clipped to INF, lowest spike index.
  function automatic logic [W-1:0] model(input logic [WINDOW-1:0] mask);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int i = 0; i < WINDOW; i++) begin
      if (mask[i]) begin
        n++;
        if (first < 0) first = i;
      end
    end
    if (n >= (1 << V_SIZE)) n = (1 << (V_SIZE + 1)) - 1;
    return pack(V_SIZE'(0) + (V_SIZE+1)'(n),
                (first < 0) ? '0 : T_SIZE'(first),
                first >= 0);
  endfunction

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got count=%0d first=%0d fv=%0b ov=%0b, want count=%0d first=%0d fv=%0b ov=%0b",
                  name, act[W:W-V_SIZE], act[T_SIZE+1:2], act[1], act[0],
                  exp[W:W-V_SIZE], exp[T_SIZE+1:2], exp[1], exp[0]);
  endtask

  // Driver: apply one cycle of inputs, sampled by the next rising edge.
  task automatic step(input logic e, input logic s, input logic c);
    @(negedge clk);
    en = e;
    spike_in = s;
    clear = c;
  endtask

  task automatic drive_window(input logic [WINDOW-1:0] mask, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    for (int i = 0; i < WINDOW; i++) step(1'b1, mask[i], 1'b0);
  endtask

  // Scoreboard: every out_valid pulse must match the oldest queued result.
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out_valid: got count=%0d first=%0d fv=%0b, want no pulse",
                 count_out, first_out, first_valid);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("window", {count_out, first_out, first_valid, 1'b1}, {e, 1'b1});
      end
    end
  end

  initial begin
    logic [WINDOW-1:0] m;
    rstn = 1'b0;
    en = 1'b0;
    clear = 1'b0;
    spike_in = 1'b1;

    vecs[0] = '{16'h0224, 5'd3,  5'd2,  1'b1};  // sparse t=2,5,9
    vecs[1] = '{16'hFFFF, 5'd31, 5'd0,  1'b1};  // 16 spikes -> INF
    vecs[2] = '{16'hFFFE, 5'd15, 5'd1,  1'b1};  // 15 spikes, none at t=0
    vecs[3] = '{16'h8000, 5'd1,  5'd15, 1'b1};  // only last-cycle spike
    vecs[4] = '{16'h0000, 5'd0,  5'd0,  1'b0};  // empty after edge spike
    vecs[5] = '{16'h0001, 5'd1,  5'd0,  1'b1};  // only first-cycle spike

    repeat (2) @(negedge clk);
    check("reset_state", {count_out, first_out, first_valid, out_valid}, '0);
    rstn = 1'b1;

    for (int i = 0; i < 6; i++)
      drive_window(vecs[i].mask, pack(vecs[i].exp_count, vecs[i].exp_first, vecs[i].exp_fv));

    for (int i = 0; i < 4; i++) begin
      m = WINDOW'($urandom_range(0, 65535));
      drive_window(m, model(m));
    end

    // en gaps: low 3 cycles before t=4, low 7 cycles before t=10, spike_in
    // high during gaps; enabled spikes at t=4 and t=12.
    exp_q.push_back(pack(5'd2, 5'd4, 1'b1));
    for (int i = 0; i < WINDOW; i++) begin
      if (i == 4)  repeat (3) step(1'b0, 1'b1, 1'b0);
      if (i == 10) repeat (7) step(1'b0, 1'b1, 1'b0);
      step(1'b1, (i == 4) || (i == 12), 1'b0);
    end

    // clear at t=8 after 4 spikes: results from the previous window held.
    for (int i = 0; i < 8; i++) step(1'b1, i < 4, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("clear_hold", {count_out, first_out, first_valid, out_valid},
          {pack(5'd2, 5'd4, 1'b1), 1'b0});
    // that cycle was t=0 of the restarted window; finish it with a spike at t=3
    exp_q.push_back(pack(5'd1, 5'd3, 1'b1));
    for (int i = 1; i < WINDOW; i++) step(1'b1, i == 3, 1'b0);

    // reset mid-window with 5 spikes accumulated
    for (int i = 0; i < 7; i++) step(1'b1, i < 5, 1'b0);
    @(negedge clk);
    en = 1'b0;
    #2 rstn = 1'b0;
    #1 check("reset_async", {count_out, first_out, first_valid, out_valid}, '0);
    @(negedge clk);
    check("reset_hold", {count_out, first_out, first_valid, out_valid}, '0);
    rstn = 1'b1;
    drive_window('0, pack(5'd0, 5'd0, 1'b0));

    // drain and confirm every queued window produced its pulse
    repeat (4) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL missing_out_valid: got %0d pending results, want 0", exp_q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
